// File: rtl/gpio_apb_irq_if.sv
// APB3 signal bundle between the peripheral bus and the GPIO controller.
interface gpio_apb_irq_if;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/gpio_apb_irq.sv
// Parametrised APB3 GPIO controller: split pads, input synchroniser,
// atomic set/clear and per-pin level/edge interrupts with one registered irq.
module gpio_apb_irq #(
   parameter int unsigned N_PINS      = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              PCLK,
   input  logic              PRESET,
   gpio_apb_irq_if.slave     apb,
   input  logic [N_PINS-1:0] pin_in,
   output logic [N_PINS-1:0] pin_out,
   output logic [N_PINS-1:0] pin_oe,
   output logic              irq
);

   typedef enum logic [3:0] {
      REG_DIR  = 4'h0,
      REG_OUT  = 4'h1,
      REG_IN   = 4'h2,
      REG_SET  = 4'h3,
      REG_CLR  = 4'h4,
      REG_EN   = 4'h5,
      REG_TYPE = 4'h6,
      REG_POL  = 4'h7,
      REG_STAT = 4'h8
   } reg_e;

   logic [N_PINS-1:0]                  r_dir, r_out, r_en, r_type, r_pol, r_stat, r_prev;
   logic [SYNC_STAGES-1:0][N_PINS-1:0] r_sync;
   logic                               r_irq;

   logic [3:0]        w_addr;
   logic              w_access, w_err, w_wr;
   logic [N_PINS-1:0] w_wd, w_s, w_event, w_clr;
   logic [31:0]       w_rd32;
   logic              w_unused;

   assign w_addr   = apb.PADDR[5:2];
   assign w_wd     = apb.PWDATA[N_PINS-1:0];
   assign w_unused = &{1'b0, apb.PADDR[31:6], apb.PADDR[1:0], apb.PWDATA};
   assign w_access = apb.PSEL & apb.PENABLE;
   // Offsets 0x24..0x3C are unmapped; IN is read-only.
   assign w_err    = w_access & ((w_addr > REG_STAT) | (apb.PWRITE & (w_addr == REG_IN)));
   assign w_wr     = w_access & apb.PWRITE & ~w_err;
   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_clr    = (w_wr && (w_addr == REG_STAT)) ? w_wd : '0;

   always_comb begin
      for (int unsigned i = 0; i < N_PINS; i++) begin
         if (r_type[i])
            w_event[i] = r_pol[i] ? (w_s[i] & ~r_prev[i]) : (~w_s[i] & r_prev[i]);
         else
            w_event[i] = (w_s[i] == r_pol[i]);
      end
   end

   always_comb begin
      w_rd32 = '0;
      case (w_addr)
         REG_DIR:  w_rd32[N_PINS-1:0] = r_dir;
         REG_OUT:  w_rd32[N_PINS-1:0] = r_out;
         REG_IN:   w_rd32[N_PINS-1:0] = w_s;
         REG_EN:   w_rd32[N_PINS-1:0] = r_en;
         REG_TYPE: w_rd32[N_PINS-1:0] = r_type;
         REG_POL:  w_rd32[N_PINS-1:0] = r_pol;
         REG_STAT: w_rd32[N_PINS-1:0] = r_stat;
         default:  w_rd32 = '0;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_dir  <= '0;
         r_out  <= '0;
         r_en   <= '0;
         r_type <= '0;
         r_pol  <= '0;
         r_stat <= '0;
         r_prev <= '0;
         r_sync <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
         r_prev <= w_s;
         // New events win over a same-cycle W1C.
         r_stat <= (r_stat & ~w_clr) | (r_en & w_event);
         r_irq  <= |(r_stat & r_en);
         if (w_wr) begin
            case (w_addr)
               REG_DIR:  r_dir  <= w_wd;
               REG_OUT:  r_out  <= w_wd;
               REG_SET:  r_out  <= r_out | w_wd;
               REG_CLR:  r_out  <= r_out & ~w_wd;
               REG_EN:   r_en   <= w_wd;
               REG_TYPE: r_type <= w_wd;
               REG_POL:  r_pol  <= w_wd;
               default:  ;
            endcase
         end
      end
   end

   assign apb.PRDATA  = (w_access && !apb.PWRITE && !w_err) ? w_rd32 : '0;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = w_err;
   assign pin_out     = r_out;
   assign pin_oe      = r_dir;
   assign irq         = r_irq;

endmodule
